player_cmd_scheduler: RTL and testbench

// - Frame-rate command sequencer between raw button inputs and the Player

---
 rtl/player_cmd_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_player_cmd_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_cmd_scheduler.sv
// Frame-rate command sequencer between raw buttons and the Player datapath.
// Optional hit-stun is compiled in with `define PLAYER_STUN_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | free: defend > jump > squat > movement
// JUMP     | jump lock-out, movement only, late jump edges buffered
// DEFEND   | defend issued while held, up to DEFEND_MAX_FRAMES ticks
// COOLDOWN | defend recovery, movement only
// STUN     | hit recovery, no commands (PLAYER_STUN_EN only)
module player_cmd_scheduler #(
    parameter int JUMP_LOCK_FRAMES   = 16,
    parameter int JUMP_BUF_FRAMES    = 4,
    parameter int DEFEND_MAX_FRAMES  = 30,
    parameter int DEFEND_COOL_FRAMES = 20,
    parameter int STUN_FRAMES        = 12
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       frame_tick_i,
    input  logic       btn_right_i,
    input  logic       btn_left_i,
    input  logic       btn_jump_i,
    input  logic       btn_squat_i,
    input  logic       btn_defend_i,
    input  logic       hit_i,
    output logic       right_o,
    output logic       left_o,
    output logic       jump_o,
    output logic       squat_o,
    output logic       defend_o,
    output logic [2:0] state_o,
    output logic       jump_pending_o
);

    localparam int LOCK_W = $clog2(JUMP_LOCK_FRAMES + 1);
    localparam int DEF_W  = $clog2(DEFEND_MAX_FRAMES + 1);
    localparam int COOL_W = $clog2(DEFEND_COOL_FRAMES + 1);

    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(JUMP_LOCK_FRAMES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(JUMP_LOCK_FRAMES - 1);
    localparam logic [LOCK_W-1:0] BUF_START = LOCK_W'(JUMP_LOCK_FRAMES - JUMP_BUF_FRAMES);
    localparam logic [DEF_W-1:0]  DEF_MAX   = DEF_W'(DEFEND_MAX_FRAMES);
    localparam logic [COOL_W-1:0] COOL_MAX  = COOL_W'(DEFEND_COOL_FRAMES);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(DEFEND_COOL_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_JUMP   = 3'd1,
        S_DEFEND = 3'd2,
        S_COOL   = 3'd3,
        S_STUN   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [DEF_W-1:0]   def_cnt_q, def_cnt_d;
    logic [COOL_W-1:0]  cool_cnt_q, cool_cnt_d;
    logic               jump_pending_q, jump_pending_d;
    logic               jump_prev_q, jump_prev_d;
    logic [4:0]         cmd_q, cmd_d;     // {right, left, jump, squat, defend}

    logic jump_edge;
    logic move_r;
    logic move_l;
    logic def_hold;

    assign jump_edge = btn_jump_i & ~jump_prev_q;
    assign move_r    = btn_right_i & ~btn_left_i;
    assign move_l    = btn_left_i & ~btn_right_i;
    assign def_hold  = btn_defend_i && (def_cnt_q < DEF_MAX);

`ifdef PLAYER_STUN_EN
    localparam int STUN_W = $clog2(STUN_FRAMES + 1);
    localparam logic [STUN_W-1:0] STUN_MAX  = STUN_W'(STUN_FRAMES);
    localparam logic [STUN_W-1:0] STUN_LAST = STUN_W'(STUN_FRAMES - 1);

    logic [STUN_W-1:0] stun_cnt_q, stun_cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stun_cnt_q <= '0;
        end else begin
            stun_cnt_q <= stun_cnt_d;
        end
    end
`else
    logic unused_stun;
    assign unused_stun = hit_i ^ (STUN_FRAMES > 0);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= S_IDLE;
            lock_cnt_q     <= '0;
            def_cnt_q      <= '0;
            cool_cnt_q     <= '0;
            jump_pending_q <= 1'b0;
            jump_prev_q    <= 1'b0;
            cmd_q          <= '0;
        end else begin
            state_q        <= state_d;
            lock_cnt_q     <= lock_cnt_d;
            def_cnt_q      <= def_cnt_d;
            cool_cnt_q     <= cool_cnt_d;
            jump_pending_q <= jump_pending_d;
            jump_prev_q    <= jump_prev_d;
            cmd_q          <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_tick_i) begin
            case (state_q)
                S_IDLE: begin
                    if (btn_defend_i) begin
                        state_d = S_DEFEND;
                    end else if (jump_edge || jump_pending_q) begin
                        state_d = S_JUMP;
                    end
                end
                S_JUMP: begin
                    if (lock_cnt_q == LOCK_LAST) state_d = S_IDLE;
                end
                S_DEFEND: begin
                    if (!def_hold) state_d = S_COOL;
                end
                S_COOL: begin
                    if (cool_cnt_q == COOL_LAST) state_d = S_IDLE;
                end
`ifdef PLAYER_STUN_EN
                S_STUN: begin
                    if (stun_cnt_q == STUN_LAST) state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
`ifdef PLAYER_STUN_EN
        if (hit_i) state_d = S_STUN;
`endif
    end

    always_comb begin
        cmd_d          = '0;
        lock_cnt_d     = lock_cnt_q;
        def_cnt_d      = def_cnt_q;
        cool_cnt_d     = cool_cnt_q;
        jump_pending_d = jump_pending_q;
        jump_prev_d    = jump_prev_q;
`ifdef PLAYER_STUN_EN
        stun_cnt_d     = stun_cnt_q;
`endif
        if (frame_tick_i) begin
            jump_prev_d = btn_jump_i;
            case (state_q)
                S_IDLE: begin
                    if (btn_defend_i) begin
                        cmd_d[0]  = 1'b1;
                        def_cnt_d = DEF_W'(1);
                    end else if (jump_edge || jump_pending_q) begin
                        cmd_d[4:2]     = {move_r, move_l, 1'b1};
                        jump_pending_d = 1'b0;
                        lock_cnt_d     = '0;
                    end else if (btn_squat_i) begin
                        cmd_d[1] = 1'b1;
                    end else begin
                        cmd_d[4:3] = {move_r, move_l};
                    end
                end
                S_JUMP: begin
                    cmd_d[4:3] = {move_r, move_l};
                    lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
                    // Edges late in the arc are remembered, earlier ones are lost.
                    if (jump_edge && (lock_cnt_q >= BUF_START)) jump_pending_d = 1'b1;
                end
                S_DEFEND: begin
                    if (def_hold) begin
                        cmd_d[0]  = 1'b1;
                        def_cnt_d = def_cnt_q + 1'b1;
                    end else begin
                        cool_cnt_d = '0;
                    end
                end
                S_COOL: begin
                    cmd_d[4:3] = {move_r, move_l};
                    cool_cnt_d = (cool_cnt_q == COOL_MAX) ? cool_cnt_q : cool_cnt_q + 1'b1;
                end
`ifdef PLAYER_STUN_EN
                S_STUN: begin
                    stun_cnt_d = (stun_cnt_q == STUN_MAX) ? stun_cnt_q : stun_cnt_q + 1'b1;
                end
`endif
                default: ;
            endcase
        end
`ifdef PLAYER_STUN_EN
        // A hit overrides whatever the same tick decided.
        if (hit_i) begin
            cmd_d          = '0;
            jump_pending_d = 1'b0;
            stun_cnt_d     = '0;
        end
`endif
    end

    assign {right_o, left_o, jump_o, squat_o, defend_o} = cmd_q;
    assign state_o        = state_q;
    assign jump_pending_o = jump_pending_q;

endmodule

// File: tb/tb_player_cmd_scheduler.sv
// Bench for player_cmd_scheduler: constant vector table, hand-written corner
// sequences and randomized stimulus against a frames-remaining reference model.
module tb_player_cmd_scheduler;

    localparam int LOCK = 16;
    localparam int BUFN = 4;
    localparam int DMAX = 30;
    localparam int COOL = 20;
    localparam int STUN = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_right = 1'b0, btn_left = 1'b0, btn_jump = 1'b0;
    logic       btn_squat = 1'b0, btn_defend = 1'b0, hit = 1'b0;
    logic       right, left, jump, squat, defend;
    logic [2:0] state;
    logic       jump_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    player_cmd_scheduler dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .frame_tick_i   (frame_tick),
        .btn_right_i    (btn_right),
        .btn_left_i     (btn_left),
        .btn_jump_i     (btn_jump),
        .btn_squat_i    (btn_squat),
        .btn_defend_i   (btn_defend),
        .hit_i          (hit),
        .right_o        (right),
        .left_o         (left),
        .jump_o         (jump),
        .squat_o        (squat),
        .defend_o       (defend),
        .state_o        (state),
        .jump_pending_o (jump_pending)
    );

    // Reference model: modes are the visible state numbers, timers count the
    // frames still remaining rather than frames elapsed.
    int       m_mode;
    int       m_jump_left;
    int       m_def_used;
    int       m_cool_left;
    int       m_stun_left;
    bit       m_buf;
    bit       m_prev;
    bit [4:0] e_cmd;            // {right, left, jump, squat, defend}

    task automatic model_reset();
        m_mode = 0; m_jump_left = 0; m_def_used = 0; m_cool_left = 0;
        m_stun_left = 0; m_buf = 0; m_prev = 0; e_cmd = '0;
    endtask

    task automatic model_edge(input bit tk, input bit [4:0] b, input bit h, input bit rn);
        bit edge_j, mr, ml;
        e_cmd = '0;
        if (!rn) begin
            model_reset();
            return;
        end
        if (tk) begin
            edge_j = b[2] && !m_prev;
            m_prev = b[2];
            mr = b[4] && !b[3];
            ml = b[3] && !b[4];
            case (m_mode)
                0: begin
                    if (b[0]) begin
                        e_cmd = 5'b00001; m_mode = 2; m_def_used = 1;
                    end else if (edge_j || m_buf) begin
                        e_cmd = {mr, ml, 3'b100}; m_mode = 1; m_jump_left = LOCK; m_buf = 0;
                    end else if (b[1]) begin
                        e_cmd = 5'b00010;
                    end else begin
                        e_cmd = {mr, ml, 3'b000};
                    end
                end
                1: begin
                    e_cmd = {mr, ml, 3'b000};
                    if (edge_j && m_jump_left <= BUFN) m_buf = 1;
                    m_jump_left--;
                    if (m_jump_left == 0) m_mode = 0;
                end
                2: begin
                    if (b[0] && m_def_used < DMAX) begin
                        e_cmd = 5'b00001; m_def_used++;
                    end else begin
                        m_mode = 3; m_cool_left = COOL;
                    end
                end
                3: begin
                    e_cmd = {mr, ml, 3'b000};
                    m_cool_left--;
                    if (m_cool_left == 0) m_mode = 0;
                end
                default: begin
                    m_stun_left--;
                    if (m_stun_left == 0) m_mode = 0;
                end
            endcase
        end
`ifdef PLAYER_STUN_EN
        if (h) begin
            m_mode = 4; m_stun_left = STUN; m_buf = 0; e_cmd = '0;
        end
`endif
    endtask

    function automatic int dut_vec();
        return int'({right, left, jump, squat, defend, state, jump_pending});
    endfunction

    function automatic int model_vec();
        return int'({e_cmd, m_mode[2:0], m_buf});
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, predict, compare against the model after the edge.
    task automatic step(input bit tk, input bit [4:0] b, input bit h, input bit rn);
        @(negedge clk);
        frame_tick = tk;
        {btn_right, btn_left, btn_jump, btn_squat, btn_defend} = b;
        hit = h;
        rst_n = rn;
        model_edge(tk, b, h, rn);
        @(posedge clk);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        step(1'b0, 5'b0, 1'b0, 1'b0);
        check("reset", dut_vec(), 0);
    endtask

    task automatic jump_buf_seq(input int edge_lock, input bit exp_pend);
        do_reset();
        step(1'b1, 5'b00100, 1'b0, 1'b1);
        for (int k = 1; k <= LOCK; k++) begin
            bit jb;
            jb = (k - 1 >= edge_lock);
            step(1'b1, {2'b00, jb, 2'b00}, 1'b0, 1'b1);
            if (k - 1 == edge_lock) check("buf_pending", int'(jump_pending), int'(exp_pend));
        end
        check("buf_exit_state", int'(state), 0);
        step(1'b1, 5'b00100, 1'b0, 1'b1);
        check("buf_jump_issue", int'(jump), int'(exp_pend));
    endtask

    typedef struct {
        bit       tick;
        bit [4:0] btn;
        bit [4:0] exp_cmd;
        int       exp_state;
        bit       exp_pend;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit [4:0] hold;

        // {R,L,J,S,D} in, {right,left,jump,squat,defend} out
        vecs[0]  = '{1'b0, 5'b10000, 5'b00000, 0, 1'b0};
        vecs[1]  = '{1'b1, 5'b10000, 5'b10000, 0, 1'b0};
        vecs[2]  = '{1'b0, 5'b10000, 5'b00000, 0, 1'b0};
        vecs[3]  = '{1'b1, 5'b11000, 5'b00000, 0, 1'b0};
        vecs[4]  = '{1'b1, 5'b01000, 5'b01000, 0, 1'b0};
        vecs[5]  = '{1'b1, 5'b10010, 5'b00010, 0, 1'b0};
        vecs[6]  = '{1'b1, 5'b10100, 5'b10100, 1, 1'b0};
        vecs[7]  = '{1'b1, 5'b10111, 5'b10000, 1, 1'b0};
        vecs[8]  = '{1'b0, 5'b00000, 5'b00000, 1, 1'b0};
        vecs[9]  = '{1'b1, 5'b01000, 5'b01000, 1, 1'b0};
        vecs[10] = '{1'b1, 5'b00100, 5'b00000, 1, 1'b0};

        model_reset();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].tick, vecs[i].btn, 1'b0, 1'b1);
            check($sformatf("vec%0d", i), dut_vec(),
                  int'({vecs[i].exp_cmd, 3'(vecs[i].exp_state), vecs[i].exp_pend}));
        end

        // Jump lock-out: held button never re-jumps, IDLE after 16 JUMP ticks.
        do_reset();
        step(1'b1, 5'b00100, 1'b0, 1'b1);
        check("lock_first_jump", int'({jump, state}), int'({1'b1, 3'd1}));
        for (int k = 1; k <= LOCK; k++) begin
            step(1'b1, 5'b00100, 1'b0, 1'b1);
            check("lock_no_rejump", int'(jump), 0);
        end
        check("lock_exit_state", int'(state), 0);

        jump_buf_seq(13, 1'b1);
        jump_buf_seq(5, 1'b0);
        jump_buf_seq(11, 1'b0);
        jump_buf_seq(12, 1'b1);
        jump_buf_seq(15, 1'b1);

        // Defend held: ticks 1..30 defend, COOLDOWN at 31, re-trigger at 52.
        do_reset();
        for (int t = 1; t <= 52; t++) begin
            step(1'b1, 5'b00001, 1'b0, 1'b1);
            check($sformatf("def_t%0d", t), int'(defend), int'(t <= DMAX || t == 52));
            if (t == 31) check("def_to_cool", int'(state), 3);
            if (t == 51) check("cool_to_idle", int'(state), 0);
            step(1'b0, 5'b00001, 1'b0, 1'b1);
        end

        // Defend masks jump and squat; reset mid-DEFEND aborts it.
        do_reset();
        step(1'b1, 5'b00001, 1'b0, 1'b1);
        step(1'b1, 5'b10111, 1'b0, 1'b1);
        check("def_only", dut_vec(), int'({5'b00001, 3'd2, 1'b0}));
        step(1'b1, 5'b00101, 1'b0, 1'b0);
        check("rst_mid_def", dut_vec(), 0);
        step(1'b1, 5'b00100, 1'b0, 1'b1);
        check("edge_after_rst", int'({jump, state}), int'({1'b1, 3'd1}));

`ifdef PLAYER_STUN_EN
        // Hit during JUMP with a buffered jump: STUN for 12 ticks, buffer lost.
        do_reset();
        step(1'b1, 5'b00100, 1'b0, 1'b1);
        for (int k = 1; k <= 14; k++) step(1'b1, {2'b00, k == 14, 2'b00}, 1'b0, 1'b1);
        check("stun_pre_pend", int'(jump_pending), 1);
        step(1'b1, 5'b10100, 1'b1, 1'b1);
        check("stun_enter", int'({state, jump_pending}), int'({3'd4, 1'b0}));
        for (int k = 1; k <= STUN; k++) begin
            step(1'b1, 5'b10101, 1'b0, 1'b1);
            check("stun_quiet", int'({right, left, jump, squat, defend}), 0);
        end
        check("stun_exit", int'(state), 0);
`endif

        // Randomized run with long button holds and rare hits/resets.
        do_reset();
        hold = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int j = 0; j < 5; j++)
                if ($urandom_range(0, 7) == 0) hold[j] = ~hold[j];
            step(1'($urandom_range(0, 1)), hold, ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 699) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
